watch_set_ctrl: RTL and testbench
=================================

# watch_set_ctrl

Mode and time-setting controller for the 4-digit min:sec watch. It owns the minute and second BCD registers and runs them from the 1 s tick. Debounced button pulses switch it between run and set modes and adjust the selected field. It also drives blink blanking for the selected field. Its BCD output feeds `fnd_4digit_cntr` directly; blanking is applied by the top level on the segment path.

## Interface
Parameters:
- `BLINK_MS`, default 500: number of `clk_msec` pulses per blink half-period.

Ports:
- `clk`  in  1: system clock.
- `reset_p`  in  1: reset, asynchronous, active-high.
- `clk_msec`  in  1: 1-cycle pulse every 1 ms, from the `clock_div_1000` chain.
- `clk_sec`  in  1: 1-cycle pulse every 1 s.
- `btn_pe`  in  3: debounced 1-cycle rising-edge pulses, one per button.
  - [0] MODE
  - [1] UP
  - [2] DOWN
- `value`  out  16: BCD display value {min10, min1, sec10, sec1}.
- `blank`  out  4: per-digit blank, active-high, same bit order as `value` nibbles.
- `mode`  out  2: current state (RUN=0, SET_MIN=1, SET_SEC=2).

## Operation
- FSM states: RUN, SET_MIN, SET_SEC.
- MODE pulse advances the state: RUN -> SET_MIN -> SET_SEC -> RUN.
- RUN:
  - `clk_sec` increments seconds.
  - Seconds 59 -> 00 increments minutes in the same cycle.
  - Minutes 59 -> 00 wraps; no carry out.
  - UP and DOWN are ignored.
- SET_MIN and SET_SEC:
  - The time is frozen; `clk_sec` is ignored and is not queued.
  - UP increments only the selected field, mod 60; 59 -> 00, no carry into minutes.
  - DOWN decrements only the selected field; 00 -> 59, no borrow.
- BCD rules:
  - Each ones digit stays in 0..9; each tens digit stays in 0..5.
  - Increment: ones 9 -> 0 and tens + 1; tens 5 with ones 9 -> 00.
  - Decrement: ones 0 -> 9 and tens - 1; 00 -> 59.
- Simultaneous pulses in one cycle: priority MODE > UP > DOWN. Lower-priority pulses in that cycle are dropped.
- A `clk_sec` arriving in the same cycle as the MODE pulse that leaves SET_SEC is ignored. Counting resumes from the next tick.
- Blink:
  - A millisecond counter counts `clk_msec` pulses up to `BLINK_MS`, toggles a phase bit, then clears.
  - Counter and phase clear to 0 (visible) on every MODE, UP or DOWN pulse.
  - In RUN, `blank` = 0000.
  - In SET_MIN, `blank` = {phase, phase, 0, 0}.
  - In SET_SEC, `blank` = {0, 0, phase, phase}.

## Timing
- All outputs are registered and update on the `clk` edge that samples the causing pulse: 1-cycle latency from pulse to output.
- Reset values:
  - `value` = 16'h0000.
  - `mode` = RUN.
  - `blank` = 4'b0000.
  - Blink counter and phase = 0.
- Reset is asynchronous. Asserting it mid-setting or mid-count returns every register to its reset value immediately. The first tick after release is honoured.
- Blink half-period: exactly `BLINK_MS` `clk_msec` pulses after the last clear.
- No handshake: every input pulse is acted on in its own cycle or dropped according to the rules above.

## Structure
- Shared package `watch_pkg` holds:
  - mode encoding constants RUN/SET_MIN/SET_SEC;
  - BCD limits (ONES_MAX = 9, TENS_MAX = 5).
- Sub-module `bcd60_field`: 2-digit BCD mod-60 register.
  - Ports: `clk`, `reset_p`, `inc`, `dec`, outputs `ones`, `tens`, `wrap_up`.
  - `wrap_up` is a 1-cycle pulse on 59 -> 00.
  - Instantiated twice: seconds and minutes.
  - In RUN, the controller drives minutes `inc` from seconds `wrap_up`, combinationally in the same cycle.
- The FSM and blink logic stay in `watch_set_ctrl`.

## Test plan
- Run rollover: reset, then 60 `clk_sec` pulses -> `value` = 16'h0100. Preload 59:59 via set mode, return to RUN, one `clk_sec` -> 16'h0000.
- Set minutes: MODE, UP ×3 -> `mode` = 1, `value` = 16'h0300. DOWN ×4 -> 16'h5900.
- Set seconds with frozen time: MODE ×2, UP ×10 with interleaved `clk_sec` pulses -> `value` = 16'h0010. MODE -> `mode` = 0.
- Priority: MODE and UP in the same cycle while in RUN -> `mode` = 1, `value` unchanged. UP and DOWN together in SET_SEC from 00 -> 01.
- Blink: `BLINK_MS` = 4, SET_MIN, 4 `clk_msec` pulses -> `blank` = 1100. 4 more -> 0000. UP pulse mid-period -> `blank` 0000 and the counter restarts.
- Reset mid-operation: in SET_SEC at 12:34, assert `reset_p` asynchronously -> `value` 0000, `mode` 0, `blank` 0000 before the next `clk` edge.

Source files
------------

// File: rtl/watch_pkg.sv
// Shared definitions for the min:sec watch controller.
// Mode encoding and BCD digit limits.
package watch_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_MIN = 2'd1,
        SET_SEC = 2'd2
    } mode_e;

    localparam logic [3:0] ONES_MAX = 4'd9;
    localparam logic [3:0] TENS_MAX = 4'd5;

endpackage

// File: rtl/watch_set_ctrl_bcd60.sv
// bcd60_field: two-digit BCD mod-60 register.
// Ports: clk, reset_p, inc, dec in; ones, tens BCD out; wrap_up on 59->00.
module bcd60_field
    import watch_pkg::*;
(
    input  logic       clk,
    input  logic       reset_p,
    input  logic       inc,
    input  logic       dec,
    output logic [3:0] ones,
    output logic [3:0] tens,
    output logic       wrap_up
);

    logic [3:0] ones_q, ones_d;
    logic [3:0] tens_q, tens_d;
    logic       at_max;
    logic       at_min;

    assign at_max = (ones_q == ONES_MAX) && (tens_q == TENS_MAX);
    assign at_min = (ones_q == 4'd0) && (tens_q == 4'd0);

    // Combinational so the next field can carry on the same edge.
    assign wrap_up = inc && at_max;

    always_comb begin
        ones_d = ones_q;
        tens_d = tens_q;
        if (inc) begin
            if (at_max) begin
                ones_d = 4'd0;
                tens_d = 4'd0;
            end else if (ones_q == ONES_MAX) begin
                ones_d = 4'd0;
                tens_d = tens_q + 4'd1;
            end else begin
                ones_d = ones_q + 4'd1;
            end
        end else if (dec) begin
            if (at_min) begin
                ones_d = ONES_MAX;
                tens_d = TENS_MAX;
            end else if (ones_q == 4'd0) begin
                ones_d = ONES_MAX;
                tens_d = tens_q - 4'd1;
            end else begin
                ones_d = ones_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            ones_q <= 4'd0;
            tens_q <= 4'd0;
        end else begin
            ones_q <= ones_d;
            tens_q <= tens_d;
        end
    end

    assign ones = ones_q;
    assign tens = tens_q;

endmodule

// File: rtl/watch_set_ctrl.sv
// Run/set mode controller for the min:sec watch, with blink blanking.
// Ports: clk, reset_p, clk_msec, clk_sec, btn_pe[2:0] in; value, blank, mode out.
module watch_set_ctrl
    import watch_pkg::*;
#(
    parameter int BLINK_MS = 500
) (
    input  logic        clk,
    input  logic        reset_p,
    input  logic        clk_msec,
    input  logic        clk_sec,
    input  logic [2:0]  btn_pe,
    output logic [15:0] value,
    output logic [3:0]  blank,
    output logic [1:0]  mode
);

    localparam int CW = (BLINK_MS > 1) ? $clog2(BLINK_MS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_MS - 1);

    mode_e         state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          phase_q, phase_d;
    logic [3:0]    blank_q, blank_d;

    logic btn_mode, btn_up, btn_dn;
    logic sec_inc, sec_dec, sec_wrap;
    logic min_inc, min_dec;
    logic unused_min_wrap;
    logic [3:0] sec_ones, sec_tens;
    logic [3:0] min_ones, min_tens;

    // MODE beats UP beats DOWN; losers are dropped.
    assign btn_mode = btn_pe[0];
    assign btn_up   = btn_pe[1] & ~btn_pe[0];
    assign btn_dn   = btn_pe[2] & ~btn_pe[1] & ~btn_pe[0];

    always_comb begin
        state_d = state_q;
        sec_inc = 1'b0;
        sec_dec = 1'b0;
        unique case (state_q)
            RUN: begin
                sec_inc = clk_sec;
                if (btn_mode) state_d = SET_MIN;
            end
            SET_MIN: begin
                if (btn_mode) state_d = SET_SEC;
            end
            SET_SEC: begin
                if (btn_mode) begin
                    state_d = RUN;
                end else begin
                    sec_inc = btn_up;
                    sec_dec = btn_dn;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // Separate block: minutes depend on the seconds carry.
    always_comb begin
        min_inc = 1'b0;
        min_dec = 1'b0;
        if (state_q == RUN) begin
            min_inc = sec_wrap;
        end else if (state_q == SET_MIN) begin
            min_inc = btn_up;
            min_dec = btn_dn;
        end
    end

    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (|btn_pe) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (clk_msec) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d   = '0;
                phase_d = ~phase_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        blank_d = 4'b0000;
        unique case (state_d)
            SET_MIN: blank_d = {phase_d, phase_d, 2'b00};
            SET_SEC: blank_d = {2'b00, phase_d, phase_d};
            default: blank_d = 4'b0000;
        endcase
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            state_q <= RUN;
            cnt_q   <= '0;
            phase_q <= 1'b0;
            blank_q <= 4'b0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            blank_q <= blank_d;
        end
    end

    bcd60_field u_sec (
        .clk     (clk),
        .reset_p (reset_p),
        .inc     (sec_inc),
        .dec     (sec_dec),
        .ones    (sec_ones),
        .tens    (sec_tens),
        .wrap_up (sec_wrap)
    );

    bcd60_field u_min (
        .clk     (clk),
        .reset_p (reset_p),
        .inc     (min_inc),
        .dec     (min_dec),
        .ones    (min_ones),
        .tens    (min_tens),
        .wrap_up (unused_min_wrap)
    );

    assign value = {min_tens, min_ones, sec_tens, sec_ones};
    assign blank = blank_q;
    assign mode  = state_q;

endmodule

// File: tb/tb_watch_set_ctrl.sv
// Directed scoreboard bench for watch_set_ctrl.
// Drives pulses, pushes expected outputs, pops and compares after each edge.
module tb_watch_set_ctrl;

    logic        clk = 1'b0;
    logic        reset_p;
    logic        clk_msec;
    logic        clk_sec;
    logic [2:0]  btn_pe;
    logic [15:0] value;
    logic [3:0]  blank;
    logic [1:0]  mode;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [15:0] v;
        logic [1:0]  m;
        logic [3:0]  b;
    } exp_t;

    exp_t sb[$];

    localparam logic [2:0] B_MODE = 3'b001;
    localparam logic [2:0] B_UP   = 3'b010;
    localparam logic [2:0] B_DN   = 3'b100;
    localparam logic [2:0] B_NONE = 3'b000;

    watch_set_ctrl #(.BLINK_MS(4)) dut (
        .clk      (clk),
        .reset_p  (reset_p),
        .clk_msec (clk_msec),
        .clk_sec  (clk_sec),
        .btn_pe   (btn_pe),
        .value    (value),
        .blank    (blank),
        .mode     (mode)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] bcd(int m, int s);
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    task automatic push(string tag, logic [15:0] v,
                        logic [1:0] m, logic [3:0] b);
        exp_t e;
        e.tag = tag;
        e.v   = v;
        e.m   = m;
        e.b   = b;
        sb.push_back(e);
    endtask

    task automatic chk();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_empty observed none expected entry");
            return;
        end
        e = sb.pop_front();
        checks++;
        assert (value === e.v) else begin
            errors++;
            $error("FAIL %s value observed %h expected %h",
                   e.tag, value, e.v);
        end
        checks++;
        assert (mode === e.m) else begin
            errors++;
            $error("FAIL %s mode observed %0d expected %0d",
                   e.tag, mode, e.m);
        end
        checks++;
        assert (blank === e.b) else begin
            errors++;
            $error("FAIL %s blank observed %b expected %b",
                   e.tag, blank, e.b);
        end
    endtask

    // One clock with the given pulses, sampled 1 time unit after the edge.
    task automatic cyc(logic [2:0] b, logic s, logic ms);
        btn_pe   = b;
        clk_sec  = s;
        clk_msec = ms;
        @(posedge clk);
        #1;
        btn_pe   = B_NONE;
        clk_sec  = 1'b0;
        clk_msec = 1'b0;
    endtask

    task automatic step(string tag, logic [2:0] b, logic s, logic ms,
                        logic [15:0] v, logic [1:0] m, logic [3:0] bl);
        push(tag, v, m, bl);
        cyc(b, s, ms);
        chk();
    endtask

    task automatic do_reset();
        reset_p = 1'b1;
        repeat (2) @(posedge clk);
        #3;
        reset_p = 1'b0;
        #1;
    endtask

    initial begin
        reset_p  = 1'b1;
        clk_msec = 1'b0;
        clk_sec  = 1'b0;
        btn_pe   = B_NONE;
        do_reset();
        push("reset", 16'h0000, 2'd0, 4'b0000);
        chk();

        for (int i = 1; i <= 60; i++)
            step($sformatf("tick%0d", i), B_NONE, 1'b1, 1'b0,
                 bcd(i / 60, i % 60), 2'd0, 4'b0000);

        step("pre_mode", B_MODE, 1'b0, 1'b0, 16'h0100, 2'd1, 4'b0000);
        step("pre_dn1", B_DN, 1'b0, 1'b0, 16'h0000, 2'd1, 4'b0000);
        step("pre_dn2", B_DN, 1'b0, 1'b0, 16'h5900, 2'd1, 4'b0000);
        step("pre_mode2", B_MODE, 1'b0, 1'b0, 16'h5900, 2'd2, 4'b0000);
        step("pre_dn3", B_DN, 1'b0, 1'b0, 16'h5959, 2'd2, 4'b0000);
        step("pre_run", B_MODE, 1'b0, 1'b0, 16'h5959, 2'd0, 4'b0000);
        step("wrap_all", B_NONE, 1'b1, 1'b0, 16'h0000, 2'd0, 4'b0000);

        step("smin_mode", B_MODE, 1'b0, 1'b0, 16'h0000, 2'd1, 4'b0000);
        for (int i = 1; i <= 3; i++)
            step($sformatf("smin_up%0d", i), B_UP, 1'b0, 1'b0,
                 bcd(i, 0), 2'd1, 4'b0000);
        for (int i = 1; i <= 4; i++)
            step($sformatf("smin_dn%0d", i), B_DN, 1'b0, 1'b0,
                 bcd((63 - i) % 60, 0), 2'd1, 4'b0000);

        do_reset();
        push("reset2", 16'h0000, 2'd0, 4'b0000);
        chk();

        step("prio_mu", B_MODE | B_UP, 1'b0, 1'b0,
             16'h0000, 2'd1, 4'b0000);
        step("to_ssec", B_MODE, 1'b0, 1'b0, 16'h0000, 2'd2, 4'b0000);
        step("prio_ud", B_UP | B_DN, 1'b0, 1'b0,
             16'h0001, 2'd2, 4'b0000);
        step("sec_dn1", B_DN, 1'b0, 1'b0, 16'h0000, 2'd2, 4'b0000);
        step("sec_dn0", B_DN, 1'b0, 1'b0, 16'h0059, 2'd2, 4'b0000);
        step("sec_up59", B_UP, 1'b0, 1'b0, 16'h0000, 2'd2, 4'b0000);

        for (int i = 1; i <= 10; i++) begin
            step($sformatf("frz_tick%0d", i), B_NONE, 1'b1, 1'b0,
                 bcd(0, i - 1), 2'd2, 4'b0000);
            step($sformatf("frz_up%0d", i), B_UP, 1'b0, 1'b0,
                 bcd(0, i), 2'd2, 4'b0000);
        end
        step("leave_tick", B_MODE, 1'b1, 1'b0, 16'h0010, 2'd0, 4'b0000);
        step("resume", B_NONE, 1'b1, 1'b0, 16'h0011, 2'd0, 4'b0000);

        step("blk_mode", B_MODE, 1'b0, 1'b0, 16'h0011, 2'd1, 4'b0000);
        for (int i = 1; i <= 12; i++)
            step($sformatf("blk_ms%0d", i), B_NONE, 1'b0, 1'b1,
                 16'h0011, 2'd1, ((i / 4) % 2 == 1) ? 4'b1100 : 4'b0000);
        for (int i = 1; i <= 2; i++)
            step($sformatf("blk_pre%0d", i), B_NONE, 1'b0, 1'b1,
                 16'h0011, 2'd1, 4'b1100);
        step("blk_up", B_UP, 1'b0, 1'b0, 16'h0111, 2'd1, 4'b0000);
        for (int i = 1; i <= 4; i++)
            step($sformatf("blk_rst%0d", i), B_NONE, 1'b0, 1'b1,
                 16'h0111, 2'd1, (i == 4) ? 4'b1100 : 4'b0000);
        step("blk_ssec", B_MODE, 1'b0, 1'b0, 16'h0111, 2'd2, 4'b0000);
        for (int i = 1; i <= 4; i++)
            step($sformatf("blks_ms%0d", i), B_NONE, 1'b0, 1'b1,
                 16'h0111, 2'd2, (i == 4) ? 4'b0011 : 4'b0000);

        cyc(B_MODE, 1'b0, 1'b0);
        cyc(B_MODE, 1'b0, 1'b0);
        for (int i = 0; i < 11; i++) cyc(B_UP, 1'b0, 1'b0);
        cyc(B_MODE, 1'b0, 1'b0);
        for (int i = 0; i < 23; i++) cyc(B_UP, 1'b0, 1'b0);
        push("at_1234", 16'h1234, 2'd2, 4'b0000);
        chk();

        #2;
        reset_p = 1'b1;
        #1;
        push("async_rst", 16'h0000, 2'd0, 4'b0000);
        chk();
        @(posedge clk);
        #3;
        reset_p = 1'b0;
        #1;
        step("first_tick", B_NONE, 1'b1, 1'b0, 16'h0001, 2'd0, 4'b0000);

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_left observed %0d expected 0",
                   sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
